// File: rtl/idct2_mul_arbiter_if.sv
// Request/response bus shared by the IDCT2 butterfly lanes and the
// multiplier arbiter.
//
// Handshake semantics: a request from lane i transfers on the rising edge
// where req_valid[i] && req_ready[i]. A response transfers on the rising edge
// where resp_valid && resp_ready. A requester raises req_valid without looking
// at req_ready, then holds req_valid and its operands steady until the
// transfer. resp_id/resp_data stay stable while resp_valid is high and
// resp_ready is low.
interface idct2_mul_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 7,
  parameter int DOUT_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [ID_WIDTH-1:0]           resp_id;
  logic [DOUT_WIDTH-1:0]         resp_data;

  // Requester/consumer side
  modport master (
    output req_valid, req_din0, req_din1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_din0, req_din1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/idct2_mul_arbiter.sv
// Round-robin arbiter that feeds one shared signed multiplier. Each granted
// operand pair goes through two register stages, the product stage S1 and the
// output stage S2. The requester ID travels with the product, so results come
// back tagged and in grant order.
module idct2_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 7,
  parameter int DOUT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  idct2_mul_arbiter_if.slave    bus,
  output logic                  busy
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  logic                         ce;
  logic [ID_WIDTH-1:0]          rr_ptr;
  logic [ID_WIDTH-1:0]          cand;
  logic [ID_WIDTH-1:0]          grant_id;
  logic                         grant_any;
  logic                         transfer;
  logic signed [DIN0_WIDTH-1:0] din0_g;
  logic signed [DIN1_WIDTH-1:0] din1_g;
  logic signed [PROD_WIDTH-1:0] full_prod;

  logic                         s1_valid;
  logic [ID_WIDTH-1:0]          s1_id;
  logic [DOUT_WIDTH-1:0]        s1_prod;
  logic                         s2_valid;
  logic [ID_WIDTH-1:0]          s2_id;
  logic [DOUT_WIDTH-1:0]        s2_prod;

  // The whole pipeline advances unless S2 holds a result nobody is taking.
  assign ce = !s2_valid || bus.resp_ready;

  // Pick the first valid requester, searching from rr_ptr upward with wrap.
  always_comb begin
    cand      = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  // A grant exists only out of reset and while the pipeline can move.
  assign transfer = reset_n && ce && grant_any;

  // Drive ready one-hot to the granted lane, or zero.
  always_comb begin
    bus.req_ready = '0;
    if (transfer) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  // Select the granted operands and form the full-width signed product.
  always_comb begin
    din0_g    = bus.req_din0[int'(grant_id)*DIN0_WIDTH +: DIN0_WIDTH];
    din1_g    = bus.req_din1[int'(grant_id)*DIN1_WIDTH +: DIN1_WIDTH];
    full_prod = din0_g * din1_g;
  end

  // Pipeline registers and round-robin pointer. All of them freeze when ce=0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_prod  <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_prod  <= '0;
    end else if (ce) begin
      s1_valid <= transfer;
      s1_id    <= grant_id;
      s1_prod  <= full_prod[DOUT_WIDTH-1:0];
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_prod  <= s1_prod;
      if (transfer) begin
        rr_ptr <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  assign bus.resp_valid = s2_valid;
  assign bus.resp_id    = s2_id;
  assign bus.resp_data  = s2_prod;
  assign busy           = s1_valid || s2_valid;

endmodule

// File: tb/tb_idct2_mul_arbiter.sv
// Bench for idct2_mul_arbiter. Directed scenarios run first, then a
// randomized run. Every cycle the outputs are compared against a
// two-slot reference pipeline, and responses are also matched against a
// queue of expected tagged products.
module tb_idct2_mul_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W0 = 32;
  localparam int W1 = 7;
  localparam int WO = 32;
  localparam int QW = IW + WO;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idct2_mul_arbiter_if #(.NUM_REQ(N), .ID_WIDTH(IW), .DIN0_WIDTH(W0),
                         .DIN1_WIDTH(W1), .DOUT_WIDTH(WO)) bus ();
  logic busy;

  idct2_mul_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .DIN0_WIDTH(W0),
                      .DIN1_WIDTH(W1), .DOUT_WIDTH(WO)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus),
    .busy    (busy)
  );

  // requester-side stimulus state
  logic [N-1:0]  rv;
  logic [W0-1:0] d0 [N];
  logic [W1-1:0] d1 [N];
  int            mode [N];   // on transfer: 0 drop valid, 1 keep valid, 2 random
  logic          rdy_in;

  always_comb begin
    bus.req_valid  = rv;
    bus.resp_ready = rdy_in;
    bus.req_din0   = '0;
    bus.req_din1   = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_din0[i*W0 +: W0] = d0[i];
      bus.req_din1[i*W1 +: W1] = d1[i];
    end
  end

  // reference model and scoreboard
  logic          m1v, m2v;
  logic [QW-1:0] m1, m2;
  int            rr;
  logic [QW-1:0] exp_q[$];
  int            grant_log[$];
  logic [QW-1:0] last_resp;
  logic [QW-1:0] held;
  int            busy_cnt;
  int            xfer_cnt;
  int            checks;
  int            failures;

  function automatic logic [WO-1:0] ref_mul(logic [W0-1:0] a, logic [W1-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[WO-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refill(input int g);
    d0[g] = $urandom;
    d1[g] = W1'($urandom_range(0, 127));
    case (mode[g])
      0:       rv[g] = 1'b0;
      1:       rv[g] = 1'b1;
      default: rv[g] = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step();
    int            g;
    logic          ce;
    logic [N-1:0]  exp_rdy;
    logic [QW-1:0] got;
    #3;
    ce = !m2v || rdy_in;
    g  = -1;
    if (rst_n && ce) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && rv[(rr + k) % N]) g = (rr + k) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("resp_valid", 64'(bus.resp_valid), 64'(m2v));
    if (m2v) chk("resp_tag", 64'({bus.resp_id, bus.resp_data}), 64'(m2));
    chk("busy", 64'(busy), 64'(m1v || m2v));
    if (busy) busy_cnt++;
    if (rst_n && bus.resp_valid && rdy_in) begin
      got = {bus.resp_id, bus.resp_data};
      chk("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        chk("sb_order", 64'(got), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      last_resp = got;
    end
    if (!rst_n) begin
      m1v = 1'b0;
      m2v = 1'b0;
      rr  = 0;
      exp_q.delete();
    end else if (ce) begin
      m2v = m1v;
      m2  = m1;
      m1v = (g >= 0);
      if (g >= 0) begin
        m1 = {IW'(g), ref_mul(d0[g], d1[g])};
        exp_q.push_back(m1);
        grant_log.push_back(g);
        xfer_cnt++;
        rr = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    if (rst_n && g >= 0) refill(g);
    for (int i = 0; i < N; i++) begin
      if (mode[i] == 2 && !rv[i] && $urandom_range(0, 1) == 1) begin
        d0[i] = $urandom;
        d1[i] = W1'($urandom_range(0, 127));
        rv[i] = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int limit);
    rdy_in = 1'b1;
    for (int k = 0; k < limit && (busy || rv != '0); k++) step();
    chk(tag, 64'(busy), 64'(0));
  endtask

  initial begin
    checks = 0; failures = 0; busy_cnt = 0; xfer_cnt = 0;
    m1v = 1'b0; m2v = 1'b0; m1 = '0; m2 = '0; rr = 0; last_resp = '0; held = '0;
    rv = '0; rdy_in = 1'b1;
    for (int i = 0; i < N; i++) begin
      d0[i] = '0; d1[i] = '0; mode[i] = 0;
    end
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    // reset state
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_resp_id", 64'(bus.resp_id), 64'(0));
    chk("rst_resp_data", 64'(bus.resp_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    // single request from lane 2: 1000 * -37
    busy_cnt = 0;
    rv[2] = 1'b1; d0[2] = 32'd1000; d1[2] = 7'h5B;
    step();
    drain("t1_drain", 20);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'(2));
    chk("t1_id", 64'(last_resp[WO +: IW]), 64'(2));
    chk("t1_data", 64'(last_resp[WO-1:0]), 64'(32'hFFFF6F78));

    // all four lanes valid continuously from rr_ptr=0
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      mode[i] = 1; rv[i] = 1'b1; d0[i] = $urandom; d1[i] = W1'($urandom_range(0, 127));
    end
    for (int k = 0; k < 12; k++) step();
    for (int i = 0; i < N; i++) mode[i] = 0;
    drain("t2_drain", 40);
    chk("t2_log_len", 64'(grant_log.size() >= 8), 64'(1));
    for (int k = 0; k < 8; k++) begin
      if (grant_log.size() > k) chk("t2_grant_order", 64'(grant_log[k]), 64'(k % 4));
    end

    // truncation corners
    rv[0] = 1'b1; d0[0] = 32'h7FFFFFFF; d1[0] = 7'h40;
    drain("t3a_drain", 20);
    chk("t3a_data", 64'(last_resp[WO-1:0]), 64'(32'h00000040));
    chk("t3a_id", 64'(last_resp[WO +: IW]), 64'(0));
    rv[1] = 1'b1; d0[1] = 32'h80000000; d1[1] = 7'h3F;
    drain("t3b_drain", 20);
    chk("t3b_data", 64'(last_resp[WO-1:0]), 64'(32'h80000000));
    chk("t3b_id", 64'(last_resp[WO +: IW]), 64'(1));

    // backpressure on a lane-1 stream
    mode[1] = 1; rv[1] = 1'b1; d0[1] = $urandom; d1[1] = W1'($urandom_range(0, 127));
    for (int k = 0; k < 4; k++) step();
    rdy_in = 1'b0;
    held = {bus.resp_id, bus.resp_data};
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_held", 64'({bus.resp_id, bus.resp_data}), 64'(held));
      chk("bp_ready_low", 64'(bus.req_ready), 64'(0));
    end
    rdy_in = 1'b1;
    xfer_cnt = 0;
    for (int k = 0; k < 6; k++) step();
    chk("bp_throughput", 64'(xfer_cnt), 64'(6));
    mode[1] = 0;
    drain("bp_drain", 20);
    chk("bp_sb_empty", 64'(exp_q.size()), 64'(0));

    // reset with both stages full, then lanes 0 and 3 contend
    mode[2] = 1; rv[2] = 1'b1; d0[2] = $urandom; d1[2] = W1'($urandom_range(0, 127));
    for (int k = 0; k < 4; k++) step();
    chk("mid_full", 64'(busy), 64'(1));
    do_reset();
    chk("mid_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    mode[2] = 0; rv[2] = 1'b0;
    grant_log.delete();
    mode[0] = 1; mode[3] = 1;
    rv[0] = 1'b1; rv[3] = 1'b1;
    for (int k = 0; k < 8; k++) step();
    mode[0] = 0; mode[3] = 0;
    drain("fair_drain", 20);
    chk("fair_log_len", 64'(grant_log.size() >= 6), 64'(1));
    for (int k = 0; k < 6; k++) begin
      if (grant_log.size() > k) chk("fair_grant", 64'(grant_log[k]), 64'((k % 2) ? 3 : 0));
    end
    chk("fair_sb_empty", 64'(exp_q.size()), 64'(0));

    // randomized traffic with random backpressure
    for (int i = 0; i < N; i++) mode[i] = 2;
    for (int k = 0; k < 400; k++) begin
      rdy_in = ($urandom_range(0, 3) != 0);
      step();
    end
    for (int i = 0; i < N; i++) mode[i] = 0;
    drain("rand_drain", 60);
    chk("rand_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
